ai_ram_stream_loader: RTL and testbench
=======================================

Name: ai_ram_stream_loader

Overview:
- Upstream DMA stage of the AI RAM sector.
- Accepts a byte stream (valid/ready) from the feature/input pipeline and writes it into the sector's DMA write port (q_write/q_addr/q_data) as one frame of cmd_len bytes starting at cmd_base.
- Buffers bytes in a small FIFO. While the AI core holds the shared RAM port (core_busy), writes stall, because a DMA write overrides the core's second read port.

Parameters:
ADDR_W, 14, width of q_addr and cmd_base; address arithmetic wraps modulo 2^ADDR_W
FIFO_DEPTH, 4, stream buffer depth in bytes; must be a power of two and >= 2

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
cmd_start  in  1  one-cycle frame start request
cmd_base  in  ADDR_W  first write address of the frame
cmd_len  in  ADDR_W+1  frame length in bytes, 0..2^ADDR_W
cmd_abort  in  1  cancel the current frame
busy  out  1  high from the accepted start until the frame ends
done  out  1  one-cycle pulse when the last byte of the frame is written
aborted  out  1  one-cycle pulse when an abort takes effect
s_valid  in  1  stream byte valid
s_data  in  8  stream byte
s_ready  out  1  loader accepts a byte this cycle
core_busy  in  1  AI core owns the RAM port; no writes allowed
q_write  out  1  write strobe to the RAM sector DMA port (registered)
q_addr  out  ADDR_W  write address (registered)
q_data  out  8  write data (registered)

Behaviour:
- Reset: busy=0, done=0, aborted=0, s_ready=0, q_write=0, q_addr=0, q_data=0. FIFO emptied, state IDLE, counters cleared. A reset mid-frame discards all buffered bytes and issues no further writes.
- States: IDLE, RUN, FINISH.
- IDLE:
  - s_ready=0.
  - cmd_start with cmd_len!=0: load addr=cmd_base, accept_left=cmd_len, write_left=cmd_len; go to RUN; busy=1 from the next cycle.
  - cmd_start with cmd_len==0: done pulses the next cycle, busy stays 0, no writes.
- RUN:
  - s_ready = (FIFO not full) AND (accept_left != 0). Bytes beyond the frame length are never accepted.
  - Transfer occurs on s_valid & s_ready: push s_data, decrement accept_left.
  - Write issue: when FIFO is non-empty and core_busy=0, pop the head. Next cycle q_write=1, q_addr=addr, q_data=head. Then increment addr (wrapping 2^ADDR_W-1 -> 0) and decrement write_left.
  - At most one write per cycle; q_write is 0 in every cycle without an issue.
  - core_busy=1 blocks pops. The FIFO keeps filling until full, then s_ready drops.
  - Simultaneous push and pop on a full FIFO is not allowed, because s_ready is computed from the registered full flag.
  - Simultaneous push and pop on an empty FIFO: the push lands and no pop occurs that cycle; no bypass.
  - Latency: a byte accepted in cycle N with core_busy=0 appears on q_write in cycle N+2 (FIFO write N, pop N+1, registered output N+2).
  - When the pop of the last byte occurs (write_left becomes 0), go to FINISH.
- FINISH:
  - The final q_write is asserted this cycle.
  - done=1 for one cycle; busy stays 1 this cycle; go to IDLE (busy=0 the following cycle).
- cmd_start while busy=1: ignored, with no effect on counters.
- cmd_abort in RUN or FINISH:
  - Next cycle: flush the FIFO, q_write=0, aborted=1 for one cycle, state IDLE, busy=0.
  - Abort wins over a pending done in the same cycle; done is not pulsed.
- cmd_abort in IDLE: ignored, no pulse.
- Counters are unsigned, ADDR_W+1 bits. The FIFO count is log2(FIFO_DEPTH)+1 bits.

Test Plan:
1. base=0x0100, len=4, stream AA,BB,CC,DD back-to-back, core_busy=0 -> q_write at addresses 0x0100..0x0103 with data AA..DD; first write 2 cycles after first accept; done one cycle after the last write is issued; busy low next cycle.
2. base=0x3FFE, len=4, bytes 01..04 -> writes to 0x3FFE, 0x3FFF, 0x0000, 0x0001 (wrap).
3. len=8, core_busy=1 held 10 cycles, s_valid=1 -> exactly 4 bytes accepted, then s_ready=0 and no q_write. Release core_busy -> 8 writes in order, no byte lost or duplicated.
4. len=3, source offers 5 bytes -> only 3 accepted; s_ready=0 after the third; 3 writes; done pulses once.
5. len=6, cmd_abort after 2 writes -> aborted pulses once, no done, no further q_write. A new start (base=0x0000, len=1, byte 5A) then writes 5A to 0x0000.
6. cmd_start with len=0 -> done pulses next cycle, busy never rises, no q_write. rst asserted mid-frame -> all outputs 0 next cycle and FIFO empty.

Source files
------------

// File: rtl/ai_ram_stream_loader_if.sv
// ============================================================================
//  Module   : ai_ram_stream_loader_if
//  Purpose  : Command, byte-stream and RAM DMA write-port bundle of the loader.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface ai_ram_stream_loader_if #(
    parameter int ADDR_W = 14
);
    logic              cmd_start;
    logic [ADDR_W-1:0] cmd_base;
    logic [ADDR_W:0]   cmd_len;
    logic              cmd_abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic              s_valid;
    logic [7:0]        s_data;
    logic              s_ready;
    logic              core_busy;
    logic              q_write;
    logic [ADDR_W-1:0] q_addr;
    logic [7:0]        q_data;

    // Environment side: issues commands, sources bytes, owns core_busy.
    modport master (
        output cmd_start, cmd_base, cmd_len, cmd_abort,
        output s_valid, s_data, core_busy,
        input  busy, done, aborted, s_ready,
        input  q_write, q_addr, q_data
    );

    // Loader side.
    modport slave (
        input  cmd_start, cmd_base, cmd_len, cmd_abort,
        input  s_valid, s_data, core_busy,
        output busy, done, aborted, s_ready,
        output q_write, q_addr, q_data
    );
endinterface

`default_nettype wire

// File: rtl/ai_ram_stream_loader.sv
// ============================================================================
//  Module   : ai_ram_stream_loader
//  Purpose  : Buffers a byte stream and writes one frame into the AI RAM
//             sector DMA port, stalling while the AI core owns the port.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module ai_ram_stream_loader #(
    parameter int ADDR_W     = 14,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    ai_ram_stream_loader_if.slave  bus
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_RUN    = 2'd1;
    localparam logic [1:0] c_FINISH = 2'd2;

    localparam logic [PTR_W:0]    c_FIFO_FULL = (PTR_W+1)'(FIFO_DEPTH);
    localparam logic [PTR_W:0]    c_CNT_ONE   = (PTR_W+1)'(1);
    localparam logic [PTR_W-1:0]  c_PTR_ONE   = PTR_W'(1);
    localparam logic [ADDR_W:0]   c_LEN_ONE   = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   accept_left_q, accept_left_d;
    logic [ADDR_W:0]   write_left_q, write_left_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              done_q, done_d;
    logic              aborted_q, aborted_d;
    logic              q_write_q, q_write_d;
    logic [ADDR_W-1:0] q_addr_q, q_addr_d;
    logic [7:0]        q_data_q, q_data_d;
    logic [7:0]        fifo_mem_q [FIFO_DEPTH];

    logic w_s_ready;
    logic w_push;
    logic w_pop;
    logic w_abort;

    // Ready uses the registered count, so a push never meets a pop on a full FIFO;
    // a pop needs a registered non-empty FIFO, so there is no same-cycle bypass.
    always_comb begin
        w_s_ready = (state_q == c_RUN) && (count_q != c_FIFO_FULL) && (accept_left_q != '0);
        w_push    = bus.s_valid && w_s_ready;
        w_pop     = (state_q == c_RUN) && (count_q != '0) && !bus.core_busy;
        w_abort   = bus.cmd_abort && (state_q != c_IDLE);
    end

    always_comb begin
        state_d       = state_q;
        addr_d        = addr_q;
        accept_left_d = accept_left_q;
        write_left_d  = write_left_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        done_d        = 1'b0;
        aborted_d     = 1'b0;
        q_write_d     = 1'b0;
        q_addr_d      = q_addr_q;
        q_data_d      = q_data_q;

        if (w_push) begin
            wr_ptr_d      = wr_ptr_q + c_PTR_ONE;
            accept_left_d = accept_left_q - c_LEN_ONE;
        end

        if (w_pop) begin
            rd_ptr_d     = rd_ptr_q + c_PTR_ONE;
            q_write_d    = 1'b1;
            q_addr_d     = addr_q;
            q_data_d     = fifo_mem_q[rd_ptr_q];
            addr_d       = addr_q + c_ADDR_ONE;
            write_left_d = write_left_q - c_LEN_ONE;
        end

        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_ONE;
            2'b01:   count_d = count_q - c_CNT_ONE;
            default: count_d = count_q;
        endcase

        case (state_q)
            c_IDLE: begin
                if (bus.cmd_start) begin
                    if (bus.cmd_len != '0) begin
                        state_d       = c_RUN;
                        addr_d        = bus.cmd_base;
                        accept_left_d = bus.cmd_len;
                        write_left_d  = bus.cmd_len;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            c_RUN: begin
                // done is registered so it lines up with the final q_write.
                if (w_pop && (write_left_q == c_LEN_ONE)) begin
                    state_d = c_FINISH;
                    done_d  = 1'b1;
                end
            end
            c_FINISH: state_d = c_IDLE;
            default:  state_d = c_IDLE;
        endcase

        // Abort overrides everything above, including a done about to be raised.
        if (w_abort) begin
            state_d       = c_IDLE;
            wr_ptr_d      = '0;
            rd_ptr_d      = '0;
            count_d       = '0;
            accept_left_d = '0;
            write_left_d  = '0;
            q_write_d     = 1'b0;
            done_d        = 1'b0;
            aborted_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= c_IDLE;
            addr_q        <= '0;
            accept_left_q <= '0;
            write_left_q  <= '0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            done_q        <= 1'b0;
            aborted_q     <= 1'b0;
            q_write_q     <= 1'b0;
            q_addr_q      <= '0;
            q_data_q      <= '0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            accept_left_q <= accept_left_d;
            write_left_q  <= write_left_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            done_q        <= done_d;
            aborted_q     <= aborted_d;
            q_write_q     <= q_write_d;
            q_addr_q      <= q_addr_d;
            q_data_q      <= q_data_d;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            fifo_mem_q[wr_ptr_q] <= bus.s_data;
        end
    end

    assign bus.s_ready = w_s_ready;
    assign bus.busy    = (state_q != c_IDLE);
    assign bus.done    = done_q;
    assign bus.aborted = aborted_q;
    assign bus.q_write = q_write_q;
    assign bus.q_addr  = q_addr_q;
    assign bus.q_data  = q_data_q;

endmodule

`default_nettype wire

// File: tb/tb_ai_ram_stream_loader.sv
// ============================================================================
//  Module   : tb_ai_ram_stream_loader
//  Purpose  : Self-checking bench for ai_ram_stream_loader (frame scoreboard).
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_ai_ram_stream_loader;

    localparam int ADDR_W     = 14;
    localparam int FIFO_DEPTH = 4;
    localparam int ADDR_MASK  = (1 << ADDR_W) - 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ai_ram_stream_loader_if #(.ADDR_W(ADDR_W)) bus ();

    ai_ram_stream_loader #(
        .ADDR_W     (ADDR_W),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    // Frame model: every accepted byte must be written, in order, to base+index.
    int         exp_base = 0;
    int         exp_len  = 0;
    int         wr_idx   = 0;
    int         frame_acc = 0;
    bit         frame_active = 1'b0;
    logic [7:0] acc_q [$];
    logic [7:0] src [$];
    int         src_idx = 0;

    int wr_total = 0, done_total = 0, abort_total = 0;
    int stray_wr = 0, stray_done = 0, ready_over = 0;
    int first_acc_cyc = 0, first_wr_cyc = 0, last_wr_cyc = 0;
    int done_cyc = 0, aborted_cyc = 0, busy_fall_cyc = 0;
    int last_wr_addr = 0, last_wr_data = 0;
    bit prev_cb = 1'b0, prev_busy = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, got, want);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_src(input int n);
        src.delete();
        for (int i = 0; i < n; i++) src.push_back(8'($urandom));
        src_idx = 0;
    endtask

    task automatic start_frame(input int base, input int len);
        bus.cmd_start = 1'b1;
        bus.cmd_base  = ADDR_W'(base);
        bus.cmd_len   = (ADDR_W+1)'(len);
        exp_base      = base;
        exp_len       = len;
        wr_idx        = 0;
        frame_acc     = 0;
        frame_active  = 1'b1;
        tick();
        bus.cmd_start = 1'b0;
    endtask

    // cb_mode: 0 core idle, 1 core holds the port, 2 random ownership.
    task automatic drive_stream(input int budget, input int cb_mode, input int valid_pct);
        int n = 0;
        while (src_idx < src.size() && n < budget) begin
            if (cb_mode == 0)      bus.core_busy = 1'b0;
            else if (cb_mode == 1) bus.core_busy = 1'b1;
            else                   bus.core_busy = ($urandom_range(0, 99) < 30);
            bus.s_valid = ($urandom_range(0, 99) < valid_pct);
            bus.s_data  = src[src_idx];
            @(negedge clk);
            if (bus.s_valid && bus.s_ready) src_idx++;
            tick();
            n++;
        end
        bus.s_valid = 1'b0;
    endtask

    task automatic wait_end(input int budget);
        int n = 0;
        while (bus.busy && n < budget) begin
            tick();
            n++;
        end
        check("end_timeout", 32'(bus.busy), 32'd0);
        tick();
    endtask

    // Monitor / scoreboard, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            if (bus.aborted) begin
                abort_total++;
                aborted_cyc  = cyc;
                frame_active = 1'b0;
                acc_q.delete();
            end
            if (bus.q_write) begin
                wr_total++;
                last_wr_cyc  = cyc;
                last_wr_addr = int'(bus.q_addr);
                last_wr_data = int'(bus.q_data);
                if (!frame_active) stray_wr++;
                else begin
                    if (wr_idx == 0) first_wr_cyc = cyc;
                    check("wr_addr", 32'(bus.q_addr), 32'((exp_base + wr_idx) & ADDR_MASK));
                    check("wr_nonempty", 32'(acc_q.size() > 0), 32'd1);
                    if (acc_q.size() > 0) check("wr_data", 32'(bus.q_data), 32'(acc_q.pop_front()));
                    check("wr_core_idle", 32'(prev_cb), 32'd0);
                    wr_idx++;
                end
            end
            if (bus.done) begin
                done_total++;
                done_cyc = cyc;
                if (!frame_active) stray_done++;
                else begin
                    check("done_wr_count", 32'(wr_idx), 32'(exp_len));
                    if (exp_len > 0) check("done_with_write", 32'(bus.q_write), 32'd1);
                end
                frame_active = 1'b0;
            end
            if (rst) begin
                frame_active = 1'b0;
                acc_q.delete();
            end
            if (prev_busy && !bus.busy) busy_fall_cyc = cyc;
            if (!rst && bus.s_ready && (!frame_active || frame_acc >= exp_len)) ready_over++;
            if (!rst && bus.s_valid && bus.s_ready && frame_active) begin
                if (frame_acc == 0) first_acc_cyc = cyc;
                acc_q.push_back(bus.s_data);
                frame_acc++;
            end
            prev_cb   = bus.core_busy;
            prev_busy = bus.busy;
        end
    end

    initial begin
        int d0, a0, w0, n, abort_cyc;
        bus.cmd_start = 1'b0;
        bus.cmd_base  = '0;
        bus.cmd_len   = '0;
        bus.cmd_abort = 1'b0;
        bus.s_valid   = 1'b0;
        bus.s_data    = '0;
        bus.core_busy = 1'b0;

        repeat (2) tick();
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_aborted", 32'(bus.aborted), 32'd0);
        check("rst_s_ready", 32'(bus.s_ready), 32'd0);
        check("rst_q_write", 32'(bus.q_write), 32'd0);
        check("rst_q_addr",  32'(bus.q_addr),  32'd0);
        check("rst_q_data",  32'(bus.q_data),  32'd0);
        rst = 1'b0;
        tick();

        // Back-to-back frame: latency, done alignment, busy fall.
        d0 = done_total;
        src = {8'hAA, 8'hBB, 8'hCC, 8'hDD};
        src_idx = 0;
        start_frame(32'h0100, 4);
        check("t1_busy_rise", 32'(bus.busy), 32'd1);
        drive_stream(20, 0, 100);
        check("t1_accepted", 32'(src_idx), 32'd4);
        wait_end(30);
        check("t1_writes", 32'(wr_idx), 32'd4);
        check("t1_latency", 32'(first_wr_cyc - first_acc_cyc), 32'd2);
        check("t1_done_on_last", 32'(done_cyc), 32'(last_wr_cyc));
        check("t1_busy_fall", 32'(busy_fall_cyc), 32'(done_cyc + 1));
        check("t1_done_once", 32'(done_total - d0), 32'd1);

        // Address wrap at the top of the space.
        src = {8'h01, 8'h02, 8'h03, 8'h04};
        src_idx = 0;
        start_frame(32'h3FFE, 4);
        drive_stream(20, 0, 100);
        wait_end(30);
        check("t2_writes", 32'(wr_idx), 32'd4);
        check("t2_last_addr", 32'(last_wr_addr), 32'h0001);

        // Core owns the port: FIFO fills to depth, then stalls.
        d0 = done_total;
        bus.core_busy = 1'b1;
        fill_src(8);
        start_frame(32'h0400, 8);
        drive_stream(10, 1, 100);
        check("t3_accepted", 32'(src_idx), 32'(FIFO_DEPTH));
        check("t3_ready_low", 32'(bus.s_ready), 32'd0);
        check("t3_no_write", 32'(wr_idx), 32'd0);
        bus.core_busy = 1'b0;
        drive_stream(40, 0, 100);
        check("t3_all_accepted", 32'(src_idx), 32'd8);
        wait_end(40);
        check("t3_writes", 32'(wr_idx), 32'd8);
        check("t3_none_left", 32'(acc_q.size()), 32'd0);
        check("t3_done_once", 32'(done_total - d0), 32'd1);

        // Oversupplied source, plus a start that must be ignored mid-frame.
        d0 = done_total;
        fill_src(5);
        start_frame(32'h0800, 3);
        bus.cmd_start = 1'b1;
        bus.cmd_base  = 14'h1234;
        bus.cmd_len   = 15'd1;
        tick();
        bus.cmd_start = 1'b0;
        drive_stream(15, 0, 100);
        check("t4_accepted", 32'(src_idx), 32'd3);
        wait_end(30);
        check("t4_writes", 32'(wr_idx), 32'd3);
        check("t4_done_once", 32'(done_total - d0), 32'd1);

        // Abort after two writes, then a fresh frame.
        d0 = done_total;
        a0 = abort_total;
        fill_src(6);
        start_frame(32'h0200, 6);
        drive_stream(6, 1, 100);
        bus.core_busy = 1'b0;
        n = 0;
        while (wr_idx < 2 && n < 40) begin
            tick();
            n++;
        end
        check("t5_two_writes", 32'(wr_idx >= 2), 32'd1);
        bus.cmd_abort = 1'b1;
        abort_cyc = cyc;
        tick();
        bus.cmd_abort = 1'b0;
        tick();
        w0 = wr_total;
        check("t5_aborted_cycle", 32'(aborted_cyc), 32'(abort_cyc + 1));
        check("t5_busy_low", 32'(bus.busy), 32'd0);
        check("t5_abort_once", 32'(abort_total - a0), 32'd1);
        check("t5_no_done", 32'(done_total - d0), 32'd0);
        repeat (5) tick();
        check("t5_no_more_writes", 32'(wr_total), 32'(w0));
        src = {8'h5A};
        src_idx = 0;
        start_frame(32'h0000, 1);
        drive_stream(10, 0, 100);
        wait_end(20);
        check("t5_new_writes", 32'(wr_idx), 32'd1);
        check("t5_new_addr", 32'(last_wr_addr), 32'h0000);
        check("t5_new_data", 32'(last_wr_data), 32'h005A);

        // Zero-length frame and abort while idle.
        w0 = wr_total;
        start_frame(32'h0555, 0);
        check("t6_done_pulse", 32'(bus.done), 32'd1);
        check("t6_busy_stays", 32'(bus.busy), 32'd0);
        tick();
        check("t6_done_clear", 32'(bus.done), 32'd0);
        check("t6_busy_low", 32'(bus.busy), 32'd0);
        bus.cmd_abort = 1'b1;
        tick();
        bus.cmd_abort = 1'b0;
        check("t6_idle_abort", 32'(bus.aborted), 32'd0);
        check("t6_no_writes", 32'(wr_total), 32'(w0));

        // Reset in the middle of a frame with bytes buffered.
        bus.core_busy = 1'b1;
        fill_src(3);
        start_frame(32'h0300, 8);
        drive_stream(3, 1, 100);
        rst = 1'b1;
        tick();
        check("mrst_busy",    32'(bus.busy),    32'd0);
        check("mrst_done",    32'(bus.done),    32'd0);
        check("mrst_aborted", 32'(bus.aborted), 32'd0);
        check("mrst_s_ready", 32'(bus.s_ready), 32'd0);
        check("mrst_q_write", 32'(bus.q_write), 32'd0);
        check("mrst_q_addr",  32'(bus.q_addr),  32'd0);
        check("mrst_q_data",  32'(bus.q_data),  32'd0);
        rst = 1'b0;
        bus.core_busy = 1'b0;
        w0 = wr_total;
        repeat (6) tick();
        check("mrst_fifo_empty", 32'(wr_total), 32'(w0));
        fill_src(2);
        start_frame(32'h0010, 2);
        drive_stream(20, 0, 100);
        wait_end(20);
        check("mrst_next_frame", 32'(wr_idx), 32'd2);

        // Randomized frames with random valid and core ownership.
        for (int f = 0; f < 20; f++) begin
            int base, len;
            base = int'($urandom_range(0, ADDR_MASK));
            len  = (f % 5 == 0) ? 1 : int'($urandom_range(2, 24));
            d0   = done_total;
            fill_src(len);
            start_frame(base, len);
            drive_stream(len * 12 + 40, 2, 70);
            bus.core_busy = 1'b0;
            check("rnd_accepted", 32'(src_idx), 32'(len));
            wait_end(80);
            check("rnd_writes", 32'(wr_idx), 32'(len));
            check("rnd_done_once", 32'(done_total - d0), 32'd1);
        end

        check("ready_beyond_frame", 32'(ready_over), 32'd0);
        check("stray_writes", 32'(stray_wr), 32'd0);
        check("stray_done", 32'(stray_done), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
